bootrom_ctrl: RTL and testbench

Parametrised boot ROM controller that replaces the fixed 32-bit, zero-latency boot ROM wrapper. It bridges a valid/ready request/response port to an external synchronous single-port ROM macro with 1-cycle read latency. It packs 1 or 2 ROM words per bus beat for 32/64-bit buses, flags writes, out-of-range and post-boot accesses as errors, and provides a sticky lock that seals the ROM once boot completes.

---
 rtl/bootrom_ctrl.sv | 147 ++++++++++++++
 tb/tb_bootrom_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_ctrl.sv
// bootrom_ctrl: valid/ready front end for a synchronous single-port boot ROM
// macro with 1-cycle read latency. Packs 1 or 2 ROM words per bus beat,
// rejects writes, out-of-window and post-lock accesses, and keeps a sticky
// lock that seals the ROM once boot is done.
module bootrom_ctrl #(
   parameter int unsigned          AddrWidth    = 32,
   parameter int unsigned          BusDataWidth = 64,
   parameter int unsigned          RomDataWidth = 32,
   parameter int unsigned          RomWords     = 1024,
   parameter logic [AddrWidth-1:0] BaseAddr     = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [AddrWidth-1:0]        req_addr_i,
   input  logic                        req_write_i,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ready_i,
   output logic [BusDataWidth-1:0]     rsp_rdata_o,
   output logic                        rsp_error_o,
   output logic                        rom_req_o,
   output logic [$clog2(RomWords)-1:0] rom_addr_o,
   input  logic [RomDataWidth-1:0]     rom_rdata_i,
   input  logic                        lock_i,
   output logic                        locked_o
);

   localparam int unsigned Ratio      = BusDataWidth / RomDataWidth;
   localparam int unsigned RomAw      = $clog2(RomWords);
   localparam int unsigned BeatShift  = $clog2(BusDataWidth / 8);
   localparam int unsigned RatioShift = $clog2(Ratio);
   localparam int unsigned AddrExtW   = AddrWidth + 1;
   // One extra bit so a window that fills the whole address space still compares correctly
   localparam logic [AddrWidth:0] RomBytes = AddrExtW'(RomWords) << 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_RESP  = 2'd2
   } state_e;

   state_e                  r_state;
   logic                    r_k;
   logic [RomAw-1:0]        r_base;
   logic [RomAw-1:0]        r_rom_addr;
   logic [BusDataWidth-1:0] r_rdata;
   logic                    r_rsp_valid;
   logic                    r_rsp_error;
   logic                    r_locked;

   logic [AddrWidth-1:0]    w_offset;
   logic                    w_in_range;
   logic                    w_error;
   logic [RomAw-1:0]        w_word0;
   logic [RomAw-1:0]        w_next_word;
   logic                    w_last;

   // Request decode: window offset (wrapping below BaseAddr), range and error checks
   always_comb begin
      w_offset    = req_addr_i - BaseAddr;
      w_in_range  = ({1'b0, w_offset} < RomBytes);
      w_error     = req_write_i | ~w_in_range | r_locked;
      w_word0     = RomAw'((w_offset >> BeatShift) << RatioShift);
      w_next_word = r_base + RomAw'(r_k) + RomAw'(1);
      w_last      = (r_k == 1'(Ratio - 1));
   end

   // ROM port: first word straight from the request, later words issued from FETCH
   always_comb begin
      rom_req_o  = 1'b0;
      rom_addr_o = r_rom_addr;
      if (r_state == S_IDLE && req_valid_i && !w_error) begin
         rom_req_o  = 1'b1;
         rom_addr_o = w_word0;
      end else if (r_state == S_FETCH && !w_last) begin
         rom_req_o  = 1'b1;
         rom_addr_o = w_next_word;
      end
   end

   assign req_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_error_o = r_rsp_error;
   assign rsp_rdata_o = r_rdata;
   assign locked_o    = r_locked;

   // Controller FSM with registered response, sub-word capture and sticky lock
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_k         <= 1'b0;
         r_base      <= '0;
         r_rom_addr  <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_error <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_locked <= r_locked | lock_i;
         if (rom_req_o) begin
            r_rom_addr <= rom_addr_o;
         end
         unique case (r_state)
            S_IDLE: begin
               if (req_valid_i) begin
                  r_rdata <= '0;
                  r_k     <= 1'b0;
                  r_base  <= w_word0;
                  if (w_error) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_error <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               for (int unsigned i = 0; i < Ratio; i++) begin
                  if (r_k == 1'(i)) begin
                     r_rdata[i*RomDataWidth +: RomDataWidth] <= rom_rdata_i;
                  end
               end
               if (w_last) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_error <= 1'b0;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_error <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bootrom_ctrl.sv
// Testbench for bootrom_ctrl: a 64-bit instance at base 0 and a 32-bit
// instance at base 0x1000, each with a behavioural 1-cycle ROM and a
// scoreboard monitor checking response cycle, data and error flag.
module tb_bootrom_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // 64-bit instance
   logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_error;
   logic [31:0] a_req_addr, a_rom_rdata;
   logic [63:0] a_rsp_rdata;
   logic        a_rom_req, a_lock, a_locked;
   logic [9:0]  a_rom_addr;

   // 32-bit instance
   logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_error;
   logic [31:0] b_req_addr, b_rom_rdata;
   logic [31:0] b_rsp_rdata;
   logic        b_rom_req, b_lock, b_locked;
   logic [9:0]  b_rom_addr;

   bootrom_ctrl #(.AddrWidth(32), .BusDataWidth(64), .RomDataWidth(32), .RomWords(1024),
                  .BaseAddr(32'h0000_0000)) u_a (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
      .req_write_i(a_req_write), .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
      .rsp_rdata_o(a_rsp_rdata), .rsp_error_o(a_rsp_error), .rom_req_o(a_rom_req),
      .rom_addr_o(a_rom_addr), .rom_rdata_i(a_rom_rdata), .lock_i(a_lock), .locked_o(a_locked));

   bootrom_ctrl #(.AddrWidth(32), .BusDataWidth(32), .RomDataWidth(32), .RomWords(1024),
                  .BaseAddr(32'h0000_1000)) u_b (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
      .req_write_i(b_req_write), .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
      .rsp_rdata_o(b_rsp_rdata), .rsp_error_o(b_rsp_error), .rom_req_o(b_rom_req),
      .rom_addr_o(b_rom_addr), .rom_rdata_i(b_rom_rdata), .lock_i(b_lock), .locked_o(b_locked));

   // ROM contents: word i = A500_0000 | i, with a few hand-picked words
   logic [31:0] rom [1024];
   int unsigned a_rom_cnt = 0;
   int unsigned b_rom_cnt = 0;

   always @(posedge clk) begin
      if (a_rom_req) begin a_rom_rdata <= rom[a_rom_addr]; a_rom_cnt <= a_rom_cnt + 1; end
      if (b_rom_req) begin b_rom_rdata <= rom[b_rom_addr]; b_rom_cnt <= b_rom_cnt + 1; end
   end

   typedef struct {
      logic [63:0] data;
      logic        err;
      int unsigned at;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: compare each new response against the oldest expectation
   logic a_prev_valid = 1'b0;
   logic b_prev_valid = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (a_rsp_valid && !a_prev_valid) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_rsp", 64'd1, 64'd0);
         end else begin
            e = qa.pop_front();
            chk("a_rsp_cycle", 64'(cyc), 64'(e.at));
            chk("a_rsp_data", a_rsp_rdata, e.data);
            chk("a_rsp_err", 64'(a_rsp_error), 64'(e.err));
         end
      end
      a_prev_valid <= a_rsp_valid;
   end

   always @(negedge clk) begin
      exp_t e;
      if (b_rsp_valid && !b_prev_valid) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_rsp", 64'd1, 64'd0);
         end else begin
            e = qb.pop_front();
            chk("b_rsp_cycle", 64'(cyc), 64'(e.at));
            chk("b_rsp_data", {32'h0, b_rsp_rdata}, e.data);
            chk("b_rsp_err", 64'(b_rsp_error), 64'(e.err));
         end
      end
      b_prev_valid <= b_rsp_valid;
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Issue one request on A; returns the ROM port state seen in the accept cycle
   task automatic issue_a(input logic [31:0] addr, input logic wr, input logic [63:0] d,
                          input logic e, input int unsigned lat, input bit push,
                          output logic t_req, output logic [9:0] t_addr);
      int n = 0;
      a_req_valid = 1'b1; a_req_addr = addr; a_req_write = wr;
      while (!a_req_ready && n < 50) begin step(1); n++; end
      if (!a_req_ready) chk("a_accept_timeout", 64'd0, 64'd1);
      if (push) qa.push_back('{d, e, cyc + lat});
      @(negedge clk);
      t_req = a_rom_req; t_addr = a_rom_addr;
      step(1);
      a_req_valid = 1'b0; a_req_write = 1'b0;
   endtask

   task automatic issue_b(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                          input logic e, input int unsigned lat,
                          output logic t_req, output logic [9:0] t_addr);
      int n = 0;
      b_req_valid = 1'b1; b_req_addr = addr; b_req_write = wr;
      while (!b_req_ready && n < 50) begin step(1); n++; end
      if (!b_req_ready) chk("b_accept_timeout", 64'd0, 64'd1);
      qb.push_back('{{32'h0, d}, e, cyc + lat});
      @(negedge clk);
      t_req = b_rom_req; t_addr = b_rom_addr;
      step(1);
      b_req_valid = 1'b0; b_req_write = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((!a_req_ready || !b_req_ready) && n < 50) begin step(1); n++; end
      if (!a_req_ready || !b_req_ready) chk("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_a_ready"},  64'(a_req_ready), 64'd1);
      chk({tag, "_a_valid"},  64'(a_rsp_valid), 64'd0);
      chk({tag, "_a_rdata"},  a_rsp_rdata, 64'd0);
      chk({tag, "_a_err"},    64'(a_rsp_error), 64'd0);
      chk({tag, "_a_romreq"}, 64'(a_rom_req), 64'd0);
      chk({tag, "_a_romadr"}, 64'(a_rom_addr), 64'd0);
      chk({tag, "_a_locked"}, 64'(a_locked), 64'd0);
      chk({tag, "_b_valid"},  64'(b_rsp_valid), 64'd0);
      chk({tag, "_b_locked"}, 64'(b_locked), 64'd0);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        t_req;
      logic [9:0]  t_addr;
      int unsigned cnt0;

      for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 | 32'(i);
      rom[3] = 32'hDEAD_BEEF;
      rom[4] = 32'h1111_2222;
      rom[5] = 32'h3333_4444;

      rst_n = 1'b0;
      a_req_valid = 1'b0; a_req_addr = '0; a_req_write = 1'b0; a_rsp_ready = 1'b1; a_lock = 1'b0;
      b_req_valid = 1'b0; b_req_addr = '0; b_req_write = 1'b0; b_rsp_ready = 1'b1; b_lock = 1'b0;
      step(3);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      step(2);

      // 64-bit read of words 4,5 with both ROM requests checked
      issue_a(32'h10, 1'b0, 64'h3333_4444_1111_2222, 1'b0, 3, 1'b1, t_req, t_addr);
      chk("t1_req_T", 64'(t_req), 64'd1);
      chk("t1_addr_T", 64'(t_addr), 64'd4);
      @(negedge clk);
      chk("t1_req_T1", 64'(a_rom_req), 64'd1);
      chk("t1_addr_T1", 64'(a_rom_addr), 64'd5);
      step(1); @(negedge clk);
      chk("t1_req_T2", 64'(a_rom_req), 64'd0);
      chk("t1_addr_hold", 64'(a_rom_addr), 64'd5);
      wait_idle();

      // 32-bit read at base+0x0E -> word 3
      issue_b(32'h0000_100E, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, t_req, t_addr);
      chk("t2_req_T", 64'(t_req), 64'd1);
      chk("t2_addr_T", 64'(t_addr), 64'd3);
      wait_idle();

      // Unaligned and top-of-window reads
      issue_a(32'h17, 1'b0, 64'h3333_4444_1111_2222, 1'b0, 3, 1'b1, t_req, t_addr);
      wait_idle();
      issue_a(32'hFF8, 1'b0, 64'hA500_03FF_A500_03FE, 1'b0, 3, 1'b1, t_req, t_addr);
      chk("top_addr_T", 64'(t_addr), 64'd1022);
      wait_idle();
      issue_b(32'h0000_1FFF, 1'b0, 32'hA500_03FF, 1'b0, 2, t_req, t_addr);
      chk("b_top_addr_T", 64'(t_addr), 64'd1023);
      wait_idle();

      // Errors: write, past the window, below the base; no ROM access
      cnt0 = a_rom_cnt;
      issue_a(32'h0, 1'b1, 64'h0, 1'b1, 1, 1'b1, t_req, t_addr);
      chk("wr_noreq", 64'(t_req), 64'd0);
      wait_idle();
      issue_a(32'h1000, 1'b0, 64'h0, 1'b1, 1, 1'b1, t_req, t_addr);
      chk("oor_noreq", 64'(t_req), 64'd0);
      wait_idle();
      chk("err_rom_cnt", 64'(a_rom_cnt), 64'(cnt0));
      cnt0 = b_rom_cnt;
      issue_b(32'h0000_0FFC, 1'b0, 32'h0, 1'b1, 1, t_req, t_addr);
      wait_idle();
      issue_b(32'h0000_2000, 1'b0, 32'h0, 1'b1, 1, t_req, t_addr);
      wait_idle();
      issue_b(32'h0000_1004, 1'b1, 32'h0, 1'b1, 1, t_req, t_addr);
      wait_idle();
      chk("b_err_rom_cnt", 64'(b_rom_cnt), 64'(cnt0));

      // Response backpressure with a pending request
      a_rsp_ready = 1'b0;
      issue_a(32'h20, 1'b0, 64'hA500_0009_A500_0008, 1'b0, 3, 1'b1, t_req, t_addr);
      a_req_valid = 1'b1; a_req_addr = 32'h28; a_req_write = 1'b0;
      step(2);
      cnt0 = a_rom_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(a_rsp_valid), 64'd1);
         chk("hold_data", a_rsp_rdata, 64'hA500_0009_A500_0008);
         chk("hold_err", 64'(a_rsp_error), 64'd0);
         chk("hold_ready", 64'(a_req_ready), 64'd0);
         chk("hold_romreq", 64'(a_rom_req), 64'd0);
         step(1);
      end
      chk("hold_rom_cnt", 64'(a_rom_cnt), 64'(cnt0));
      a_rsp_ready = 1'b1;
      qa.push_back('{64'hA500_000B_A500_000A, 1'b0, cyc + 4});
      @(negedge clk);
      chk("release_ready", 64'(a_req_ready), 64'd0);
      step(1);
      @(negedge clk);
      chk("next_ready", 64'(a_req_ready), 64'd1);
      chk("next_romreq", 64'(a_rom_req), 64'd1);
      chk("next_romaddr", 64'(a_rom_addr), 64'd10);
      step(1);
      a_req_valid = 1'b0;
      wait_idle();

      // Reset during FETCH aborts the read
      issue_a(32'h40, 1'b0, 64'h0, 1'b0, 3, 1'b0, t_req, t_addr);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      step(2);
      rst_n = 1'b1;
      step(1);
      issue_a(32'h40, 1'b0, 64'hA500_0011_A500_0010, 1'b0, 3, 1'b1, t_req, t_addr);
      chk("post_rst_addr", 64'(t_addr), 64'd16);
      wait_idle();

      // Lock pulse one cycle after a read is accepted
      issue_a(32'h18, 1'b0, 64'hA500_0007_A500_0006, 1'b0, 3, 1'b1, t_req, t_addr);
      a_lock = 1'b1;
      @(negedge clk);
      chk("lock_C", 64'(a_locked), 64'd0);
      step(1);
      a_lock = 1'b0;
      @(negedge clk);
      chk("lock_C1", 64'(a_locked), 64'd1);
      wait_idle();
      issue_a(32'h18, 1'b0, 64'h0, 1'b1, 1, 1'b1, t_req, t_addr);
      chk("locked_noreq", 64'(t_req), 64'd0);
      wait_idle();
      step(3);
      chk("lock_sticky", 64'(a_locked), 64'd1);

      // Lock rising in the accept cycle does not affect that request
      b_lock = 1'b1;
      issue_b(32'h0000_1010, 1'b0, 32'h1111_2222, 1'b0, 2, t_req, t_addr);
      b_lock = 1'b0;
      wait_idle();
      issue_b(32'h0000_1010, 1'b0, 32'h0, 1'b1, 1, t_req, t_addr);
      wait_idle();

      // Only reset clears the lock
      rst_n = 1'b0;
      #1;
      chk("unlock_a", 64'(a_locked), 64'd0);
      chk("unlock_b", 64'(b_locked), 64'd0);
      step(2);
      rst_n = 1'b1;
      step(1);
      issue_a(32'h18, 1'b0, 64'hA500_0007_A500_0006, 1'b0, 3, 1'b1, t_req, t_addr);
      wait_idle();
      step(3);

      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
